mem_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single 8-bit SAM memory bus between the CPU core and the console loader/dump port. Sits between Toplevel's CPU memory interface and the 64-byte memory. It serialises accesses through a three-state FSM and matches the memory's one-cycle registered read latency. When `pause` is high it grants only the console, so memory can be loaded or inspected while the CPU is frozen.

---
 rtl/sam_pkg.sv | 17 +
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sam_pkg.sv
// Shared definitions for the SAM memory bus: FSM states, requester ids
// and bus widths.
package sam_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_CON = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing the SAM memory bus between the CPU and the
// console port. One access per IDLE -> ISSUE -> RESP pass.
//
// Handshake: a requester raises req with rw/addr/wdata stable and holds
// them until its ack. ack is a single-cycle pulse; rdata/err are valid
// only while ack is high. req still high after ack is a new access.
module mem_bus_arbiter
  import sam_pkg::*;
#(
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              con_req,
  input  logic              con_rw,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_wdata,
  output logic              con_ack,
  output logic [DATA_W-1:0] con_rdata,
  output logic              con_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  localparam logic [ADDR_W:0] LP_DEPTH = MEM_DEPTH[ADDR_W:0];

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_gnt;
  logic                r_id;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_in_range;

  logic                w_grant;
  logic                w_gnt_id;
  logic                w_cpu_cand;
  logic                w_sel_rw;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_issue;
  logic                w_resp;
  logic [DATA_W-1:0]   w_resp_data;

  // The CPU is masked while paused; on a conflict the port not granted
  // last wins.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gnt_id     = r_last_gnt;
    w_cpu_cand   = cpu_req & ~pause;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_cand && con_req) begin
          w_grant  = 1'b1;
          w_gnt_id = (r_last_gnt == ID_CON) ? ID_CPU : ID_CON;
        end else if (w_cpu_cand) begin
          w_grant  = 1'b1;
          w_gnt_id = ID_CPU;
        end else if (con_req) begin
          w_grant  = 1'b1;
          w_gnt_id = ID_CON;
        end
        if (w_grant) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign w_sel_rw    = (w_gnt_id == ID_CON) ? con_rw    : cpu_rw;
  assign w_sel_addr  = (w_gnt_id == ID_CON) ? con_addr  : cpu_addr;
  assign w_sel_wdata = (w_gnt_id == ID_CON) ? con_wdata : cpu_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= ID_CON;
      r_id       <= ID_CPU;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_last_gnt <= w_gnt_id;
        r_id       <= w_gnt_id;
        r_rw       <= w_sel_rw;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_in_range <= ({1'b0, w_sel_addr} < LP_DEPTH);
      end
    end
  end

  // All outputs decode registered state; reset clears them immediately.
  assign w_issue = (r_state == ST_ISSUE);
  assign w_resp  = (r_state == ST_RESP);

  assign mem_en    = w_issue & r_in_range;
  assign mem_rw    = mem_en & r_rw;
  assign mem_addr  = mem_en ? r_addr  : '0;
  assign mem_wdata = mem_en ? r_wdata : '0;

  assign w_resp_data = (r_rw && r_in_range) ? mem_rdata : '0;

  assign cpu_ack   = w_resp & (r_id == ID_CPU);
  assign cpu_rdata = cpu_ack ? w_resp_data : '0;
  assign cpu_err   = cpu_ack & ~r_in_range;

  assign con_ack   = w_resp & (r_id == ID_CON);
  assign con_rdata = con_ack ? w_resp_data : '0;
  assign con_err   = con_ack & ~r_in_range;

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;
  import sam_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause;
  logic       cpu_req, cpu_rw, con_req, con_rw;
  logic [7:0] cpu_addr, cpu_wdata, con_addr, con_wdata;
  logic       cpu_ack, cpu_err, con_ack, con_err;
  logic [7:0] cpu_rdata, con_rdata;
  logic       mem_en, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [7:0] pre_data;
  logic       m_last;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered-read memory model
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_rw) mem_rdata <= mem[mem_addr[5:0]];
      else        mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  mem_bus_arbiter #(.MEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .con_req(con_req), .con_rw(con_rw), .con_addr(con_addr), .con_wdata(con_wdata),
    .con_ack(con_ack), .con_rdata(con_rdata), .con_err(con_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic rw, input logic [7:0] a, input logic [7:0] d);
    cpu_rw = rw; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
  endtask

  task automatic drive_con(input logic rw, input logic [7:0] a, input logic [7:0] d);
    con_rw = rw; con_addr = a; con_wdata = d; con_req = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pause = 1'b0; cpu_req = 0; con_req = 0;
    cpu_rw = 0; cpu_addr = 0; cpu_wdata = 0; con_rw = 0; con_addr = 0; con_wdata = 0;
    pre_we = 1'b0; pre_addr = 0; pre_data = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      pre_we = 1'b1; pre_addr = 6'(i);
      pre_data = (i == 19) ? 8'h63 : 8'($urandom_range(0, 255));
      ref_mem[i] = pre_data;
    end
    tick();
    pre_we = 1'b0;
    tick();
    total++; if ({mem_en, mem_rw, mem_addr, mem_wdata} !== 18'd0) begin bad++; $display("FAIL reset_mem got=%h want=0", {mem_en, mem_rw, mem_addr, mem_wdata}); end
    total++; if ({cpu_ack, cpu_err, cpu_rdata} !== 10'd0) begin bad++; $display("FAIL reset_cpu got=%h want=0", {cpu_ack, cpu_err, cpu_rdata}); end
    total++; if ({con_ack, con_err, con_rdata} !== 10'd0) begin bad++; $display("FAIL reset_con got=%h want=0", {con_ack, con_err, con_rdata}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    m_last = ID_CON;
    tick();
  endtask

  task automatic test_alternate();
    logic exp_port, port;
    logic [7:0] ca, na;
    int got;
    exp_port = (m_last == ID_CON) ? ID_CPU : ID_CON;
    for (int r = 0; r < 4; r++) begin
      ca = 8'($urandom_range(0, 63)); na = 8'($urandom_range(0, 63));
      drive_cpu(1'b1, ca, 8'h00);
      drive_con(1'b1, na, 8'h00);
      got = 0;
      for (int k = 0; k < 12 && got < 2; k++) begin
        tick();
        if (cpu_ack || con_ack) begin
          port = con_ack ? ID_CON : ID_CPU;
          total++; if (cpu_ack && con_ack) begin bad++; $display("FAIL alt_both_ack round=%0d got=11 want=one", r); end
          total++; if (port !== exp_port) begin bad++; $display("FAIL alt_grant round=%0d got=%0d want=%0d", r, port, exp_port); end
          total++;
          if ((port ? con_rdata : cpu_rdata) !== ref_mem[(port ? na[5:0] : ca[5:0])]) begin
            bad++; $display("FAIL alt_rdata round=%0d got=%h want=%h", r, port ? con_rdata : cpu_rdata, ref_mem[(port ? na[5:0] : ca[5:0])]);
          end
          if (port) con_req = 1'b0; else cpu_req = 1'b0;
          m_last = port;
          exp_port = ~port;
          got++;
        end
      end
      total++; if (got != 2) begin bad++; $display("FAIL alt_timeout round=%0d got=%0d acks want=2", r, got); end
      cpu_req = 0; con_req = 0;
      tick();
    end
  endtask

  task automatic test_cpu_read();
    drive_cpu(1'b1, 8'd19, 8'h00);
    tick();
    total++; if ({mem_en, mem_rw, mem_addr} !== {1'b1, 1'b1, 8'd19}) begin bad++; $display("FAIL rd_issue got=%b/%b/%0d want=1/1/19", mem_en, mem_rw, mem_addr); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%b want=0", cpu_ack); end
    tick();
    total++; if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b0, 8'h63}) begin bad++; $display("FAIL rd_resp got=%b/%b/%h want=1/0/63", cpu_ack, cpu_err, cpu_rdata); end
    total++; if (con_ack !== 1'b0) begin bad++; $display("FAIL rd_con_ack got=%b want=0", con_ack); end
    cpu_req = 1'b0;
    m_last = ID_CPU;
    tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got=%b want=0", cpu_ack); end
  endtask

  task automatic test_pause();
    int en_cnt = 0, con_cnt = 0, cpu_cnt = 0;
    logic [7:0] en_addr = 0, en_data = 0;
    logic en_rw = 1'b1;
    logic done = 1'b0;
    pause = 1'b1;
    drive_cpu(1'b1, 8'd19, 8'h00);
    drive_con(1'b0, 8'd5, 8'hA5);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_en) begin en_cnt++; en_addr = mem_addr; en_data = mem_wdata; en_rw = mem_rw; end
      if (con_ack) begin con_cnt++; con_req = 1'b0; end
      if (cpu_ack) cpu_cnt++;
    end
    total++; if (en_cnt != 1) begin bad++; $display("FAIL pause_en_count got=%0d want=1", en_cnt); end
    total++; if ({en_rw, en_addr, en_data} !== {1'b0, 8'd5, 8'hA5}) begin bad++; $display("FAIL pause_write got=%b/%0d/%h want=0/5/a5", en_rw, en_addr, en_data); end
    total++; if (con_cnt != 1) begin bad++; $display("FAIL pause_con_ack got=%0d want=1", con_cnt); end
    total++; if (cpu_cnt != 0) begin bad++; $display("FAIL pause_cpu_ack got=%0d want=0", cpu_cnt); end
    ref_mem[5] = 8'hA5;
    m_last = ID_CON;
    pause = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      tick();
      if (cpu_ack) begin
        done = 1'b1;
        total++; if (cpu_rdata !== ref_mem[19]) begin bad++; $display("FAIL unpause_rdata got=%h want=%h", cpu_rdata, ref_mem[19]); end
        cpu_req = 1'b0;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL unpause_timeout got=no_ack want=ack"); end
    cpu_req = 1'b0;
    m_last = ID_CPU;
    tick();
  endtask

  task automatic test_out_of_range();
    drive_con(1'b1, 8'd70, 8'h00);
    tick();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL oor_issue_en got=%b want=0", mem_en); end
    tick();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL oor_resp_en got=%b want=0", mem_en); end
    total++; if ({con_ack, con_err, con_rdata} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL oor_resp got=%b/%b/%h want=1/1/00", con_ack, con_err, con_rdata); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL oor_cpu_ack got=%b want=0", cpu_ack); end
    con_req = 1'b0;
    m_last = ID_CON;
    tick();
  endtask

  task automatic test_reset_mid();
    logic done = 1'b0;
    drive_cpu(1'b0, 8'd30, 8'($urandom_range(0, 255)));
    tick();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rstmid_issue got=%b want=1", mem_en); end
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_en, cpu_ack} !== 2'b00) begin bad++; $display("FAIL rstmid_outputs got=%b%b want=00", mem_en, cpu_ack); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    tick();
    cpu_req = 1'b0;
    rst = 1'b0;
    m_last = ID_CON;
    tick();
    drive_cpu(1'b1, 8'd19, 8'h00);
    for (int k = 0; k < 6 && !done; k++) begin
      tick();
      if (cpu_ack) begin
        done = 1'b1;
        total++; if (cpu_rdata !== ref_mem[19]) begin bad++; $display("FAIL rstmid_read got=%h want=%h", cpu_rdata, ref_mem[19]); end
        cpu_req = 1'b0;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL rstmid_timeout got=no_ack want=ack"); end
    cpu_req = 1'b0;
    m_last = ID_CPU;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    int ack_cyc [2];
    int n = 0, en_cnt = 0, con_cnt = 0;
    a = 8'($urandom_range(0, 63));
    drive_cpu(1'b1, a, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_en) en_cnt++;
      if (con_ack) con_cnt++;
      if (cpu_ack) begin
        if (n < 2) ack_cyc[n] = cyc;
        n++;
        total++; if (cpu_rdata !== ref_mem[a[5:0]]) begin bad++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", n, cpu_rdata, ref_mem[a[5:0]]); end
        if (n == 2) cpu_req = 1'b0;
      end
    end
    total++; if (n != 2) begin bad++; $display("FAIL b2b_ack_count got=%0d want=2", n); end
    total++; if (n >= 2 && (ack_cyc[1] - ack_cyc[0]) != 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", ack_cyc[1] - ack_cyc[0]); end
    total++; if (en_cnt != 2) begin bad++; $display("FAIL b2b_en_count got=%0d want=2", en_cnt); end
    total++; if (con_cnt != 0) begin bad++; $display("FAIL b2b_con_ack got=%0d want=0", con_cnt); end
    cpu_req = 1'b0;
    m_last = ID_CPU;
  endtask

  task automatic test_random();
    logic       p_pend [2];
    logic       p_rw [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wd [2];
    logic w, inr, got_ack, got_err, lose_ack;
    logic [7:0] exp_rd, got_rd;
    p_pend[0] = 0; p_pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_pend[p] && $urandom_range(0, 1) == 1) begin
          p_pend[p] = 1'b1;
          p_rw[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = 8'($urandom_range(0, 79));
          p_wd[p]   = 8'($urandom_range(0, 255));
          if (p == 0) drive_cpu(p_rw[0], p_addr[0], p_wd[0]);
          else        drive_con(p_rw[1], p_addr[1], p_wd[1]);
        end
      end
      pause = ($urandom_range(0, 2) == 0);
      if (!(p_pend[1] || (p_pend[0] && !pause))) begin
        tick();
        total++; if ({mem_en, cpu_ack, con_ack} !== 3'b000) begin bad++; $display("FAIL rnd_idle it=%0d got=%b want=000", it, {mem_en, cpu_ack, con_ack}); end
        continue;
      end
      if (p_pend[1] && p_pend[0] && !pause) w = ~m_last;
      else w = p_pend[1] ? 1'b1 : 1'b0;
      inr = (p_addr[w] < 8'd64);
      tick();
      pause = 1'($urandom_range(0, 1));
      total++;
      if ({mem_en, mem_rw, mem_addr, mem_wdata} !== (inr ? {1'b1, p_rw[w], p_addr[w], p_wd[w]} : 18'd0)) begin
        bad++; $display("FAIL rnd_issue it=%0d got=%h want=%h", it, {mem_en, mem_rw, mem_addr, mem_wdata}, inr ? {1'b1, p_rw[w], p_addr[w], p_wd[w]} : 18'd0);
      end
      tick();
      exp_rd   = (p_rw[w] && inr) ? ref_mem[p_addr[w][5:0]] : 8'h00;
      got_ack  = w ? con_ack : cpu_ack;
      got_rd   = w ? con_rdata : cpu_rdata;
      got_err  = w ? con_err : cpu_err;
      lose_ack = w ? cpu_ack : con_ack;
      total++;
      if ({got_ack, lose_ack, got_err, got_rd} !== {1'b1, 1'b0, ~inr, exp_rd}) begin
        bad++; $display("FAIL rnd_resp it=%0d port=%0d got=%b/%b/%b/%h want=1/0/%b/%h", it, w, got_ack, lose_ack, got_err, got_rd, ~inr, exp_rd);
      end
      if (!p_rw[w] && inr) ref_mem[p_addr[w][5:0]] = p_wd[w];
      m_last = w;
      p_pend[w] = 1'b0;
      if (w) con_req = 1'b0; else cpu_req = 1'b0;
      tick();
    end
    cpu_req = 0; con_req = 0; pause = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_cpu_read();
    test_pause();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
